// File: rtl/booth_mplier_seq.sv
// booth_mplier_seq: iterative radix-4 Booth multiplier with valid/ready handshakes on both sides
// ports: clk, rst_n (async active-low); in_valid/in_ready with mplier, mcand, is_signed;
//        out_valid/out_ready with product (2*WIDTH, registered); busy high while CALC or DONE
module booth_mplier_seq #(
  parameter int WIDTH = 8,
  parameter int PP_PER_CYCLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   mplier,
  input  logic [WIDTH-1:0]   mcand,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int NGRP = WIDTH / 2 + 1;
  localparam int PW = 2 * WIDTH;
  localparam int GW = $clog2(NGRP + PP_PER_CYCLE + 1);
  localparam logic [GW-1:0] NGRP_G = GW'(NGRP);
  localparam logic [GW-1:0] STEP = GW'(PP_PER_CYCLE);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_d;
  logic [WIDTH+2:0] mx;
  logic [PW-1:0] mc, acc, sum, m1, pp;
  logic [2:0] g;
  logic [GW-1:0] grp;
  logic ms, cs, accept, last;
  assign ms = is_signed & mplier[WIDTH-1];
  assign cs = is_signed & mcand[WIDTH-1];
  assign accept = in_valid && state == IDLE;
  assign last = grp + STEP >= NGRP_G;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  assign product = acc;
  // The sum is modular, so only the low 2*WIDTH bits of every term can reach the product;
  // mx and mc shift each cycle so the current groups always sit at the bottom.
  always_comb begin
    sum = acc;
    g = '0;
    m1 = '0;
    pp = '0;
    for (int j = 0; j < PP_PER_CYCLE; j++) begin
      g = mx[2*j+2 -: 3];
      m1 = mc << (2 * j);
      pp = (g == 3'd3) ? m1 << 1 :
           (g == 3'd4) ? -(m1 << 1) :
           (g == 3'd1 || g == 3'd2) ? m1 :
           (g == 3'd5 || g == 3'd6) ? -m1 : '0;
      sum = sum + ((grp + GW'(j) < NGRP_G) ? pp : '0);
    end
  end
  always_comb begin
    state_d = state;
    state_d = (state == IDLE && in_valid) ? CALC :
              (state == CALC && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mx <= '0;
      mc <= '0;
      acc <= '0;
      grp <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        mx <= {ms, ms, mplier, 1'b0};
        mc <= {{WIDTH{cs}}, mcand};
        acc <= '0;
        grp <= '0;
      end else if (state == CALC) begin
        acc <= sum;
        grp <= grp + STEP;
        mx <= mx >> (2 * PP_PER_CYCLE);
        mc <= mc << (2 * PP_PER_CYCLE);
      end
    end
endmodule

// File: tb/tb_booth_mplier_seq.sv
// tb_booth_mplier_seq: five parametrisations run in lockstep against an arithmetic product model
module tb_booth_mplier_seq;
  logic clk = 0;
  logic rst_n, iv, ordy, sg;
  logic [15:0] mp, mc;
  logic [4:0] ir, ov, bz;
  logic [15:0] p8 [2];
  logic [31:0] p16 [3];
  int errs = 0, checks = 0;
  int nexp [5] = '{5, 3, 9, 3, 1};
  always #5 clk = ~clk;
  booth_mplier_seq #(.WIDTH(8), .PP_PER_CYCLE(1)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[0]),
    .mplier(mp[7:0]), .mcand(mc[7:0]), .is_signed(sg), .out_valid(ov[0]), .out_ready(ordy), .product(p8[0]), .busy(bz[0]));
  booth_mplier_seq #(.WIDTH(8), .PP_PER_CYCLE(2)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[1]),
    .mplier(mp[7:0]), .mcand(mc[7:0]), .is_signed(sg), .out_valid(ov[1]), .out_ready(ordy), .product(p8[1]), .busy(bz[1]));
  booth_mplier_seq #(.WIDTH(16), .PP_PER_CYCLE(1)) u2 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[2]),
    .mplier(mp), .mcand(mc), .is_signed(sg), .out_valid(ov[2]), .out_ready(ordy), .product(p16[0]), .busy(bz[2]));
  booth_mplier_seq #(.WIDTH(16), .PP_PER_CYCLE(3)) u3 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[3]),
    .mplier(mp), .mcand(mc), .is_signed(sg), .out_valid(ov[3]), .out_ready(ordy), .product(p16[1]), .busy(bz[3]));
  booth_mplier_seq #(.WIDTH(16), .PP_PER_CYCLE(9)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir[4]),
    .mplier(mp), .mcand(mc), .is_signed(sg), .out_valid(ov[4]), .out_ready(ordy), .product(p16[2]), .busy(bz[4]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b, input logic s);
    longint x, y, mask, r;
    mask = (longint'(1) << w) - 1;
    x = longint'(a) & mask;
    y = longint'(b) & mask;
    if (s && x[w-1]) x = x - (mask + 1);
    if (s && y[w-1]) y = y - (mask + 1);
    r = (x * y) & ((longint'(1) << (2 * w)) - 1);
    return r[31:0];
  endfunction
  function automatic logic [31:0] getp(input int k);
    return k < 2 ? {16'h0, p8[k]} : p16[k-2];
  endfunction
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s, input int hold);
    int lat [5];
    logic [31:0] exp [5];
    @(negedge clk);
    chk("in_ready_idle", 32'(ir), 32'h1f);
    mp = a; mc = b; sg = s; iv = 1;
    @(posedge clk);
    #1 iv = 0;
    mp = 16'($urandom); mc = 16'($urandom); sg = ~s;
    chk("busy_calc", 32'(bz), 32'h1f);
    chk("in_ready_calc", 32'(ir), 32'h0);
    for (int k = 0; k < 5; k++) begin
      lat[k] = -1;
      exp[k] = model(k < 2 ? 8 : 16, a, b, s);
    end
    for (int e = 1; e <= 20 && ov != 5'h1f; e++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 5; k++) if (ov[k] && lat[k] < 0) lat[k] = e;
    end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("latency%0d", k), lat[k], nexp[k]);
      chk($sformatf("product%0d a=%h b=%h s=%0d", k, a, b, s), getp(k), exp[k]);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      iv = h[0]; mp = 16'($urandom); mc = 16'($urandom);
      ordy = 0;
      chk("hold_valid", 32'(ov), 32'h1f);
      chk("hold_in_ready", 32'(ir), 32'h0);
      for (int k = 0; k < 5; k++) chk($sformatf("hold_product%0d", k), getp(k), exp[k]);
    end
    @(negedge clk);
    iv = 0; ordy = 1;
    @(posedge clk);
    #1 chk("release_valid", 32'(ov), 32'h0);
    chk("release_in_ready", 32'(ir), 32'h1f);
    @(negedge clk);
    ordy = 0;
  endtask
  initial begin
    logic seen;
    rst_n = 0; iv = 0; ordy = 0; sg = 0; mp = '0; mc = '0;
    #12;
    chk("rst_in_ready", 32'(ir), 32'h1f);
    chk("rst_valid", 32'(ov), 32'h0);
    chk("rst_busy", 32'(bz), 32'h0);
    for (int k = 0; k < 5; k++) chk($sformatf("rst_product%0d", k), getp(k), 32'h0);
    @(negedge clk);
    rst_n = 1;
    run_op(16'h0080, 16'h0080, 1, 0);
    chk("tp1_m128sq", 32'(p8[0]), 32'h4000);
    run_op(16'h00ff, 16'h00ff, 0, 0);
    chk("tp2_unsigned", 32'(p8[0]), 32'hfe01);
    run_op(16'h00ff, 16'h00ff, 1, 0);
    chk("tp2_signed", 32'(p8[0]), 32'h0001);
    run_op(16'h00fd, 16'h0005, 1, 0);
    chk("tp3_pp1", 32'(p8[0]), 32'hfff1);
    chk("tp3_pp2", 32'(p8[1]), 32'hfff1);
    run_op(16'h8000, 16'h7fff, 1, 10);
    run_op(16'hffff, 16'hffff, 0, 3);
    @(negedge clk);
    mp = 16'h1234; mc = 16'h0567; sg = 0; iv = 1;
    @(posedge clk);
    #1 iv = 0;
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk("midrst_valid", 32'(ov), 32'h0);
    chk("midrst_in_ready", 32'(ir), 32'h1f);
    chk("midrst_busy", 32'(bz), 32'h0);
    for (int k = 0; k < 5; k++) chk($sformatf("midrst_product%0d", k), getp(k), 32'h0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | (|ov);
    end
    chk("midrst_no_valid", 32'(seen), 32'h0);
    run_op(16'h0007, 16'h0009, 0, 0);
    chk("tp5_7x9", 32'(p8[0]), 32'h003f);
    for (int i = 0; i < 1000; i++) run_op(16'($urandom), 16'($urandom), 1'($urandom), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
